// File: rtl/uart_matmul_core.sv
// Byte-stream N x N signed 8-bit matrix multiplier: loads A and B after a 0xA5 command,
// streams C = A*B back MSB-first per element; 0x5A replays the product of the stored matrices.
module uart_matmul_core #(
    parameter int N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    // state   | meaning
    // IDLE    | waiting for a command byte
    // LOAD_A  | receiving N*N bytes of A, row-major
    // LOAD_B  | receiving N*N bytes of B, row-major
    // COMPUTE | N MAC cycles for the current C element
    // SEND    | streaming the current element, MSB first
    // ERR     | presenting 0xEE after an unknown command

    localparam int ACC_W     = 16 + $clog2(N);
    localparam int OUT_BYTES = (ACC_W + 7) / 8;
    localparam int NN        = N * N;
    localparam int IDX_W     = $clog2(NN);
    localparam int DIM_W     = $clog2(N);
    localparam int BYTE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NN - 1);
    localparam logic [DIM_W-1:0]  LAST_DIM  = DIM_W'(N - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(OUT_BYTES - 1);

    localparam logic [7:0] CMD_LOAD   = 8'hA5;
    localparam logic [7:0] CMD_REPLAY = 8'h5A;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, SEND, ERR} state_t;

    state_t state, state_next;

    logic [7:0]              a_mem [NN];
    logic [7:0]              b_mem [NN];
    logic [IDX_W-1:0]        load_idx;
    logic [DIM_W-1:0]        row, col, k;
    logic signed [ACC_W-1:0] acc;
    logic [BYTE_W-1:0]       byte_idx;

    logic [IDX_W-1:0]                  a_addr, b_addr;
    logic signed [15:0]                mac_prod;
    logic signed [OUT_BYTES*8-1:0]     acc_ext;
    logic [7:0]                        byte_sel;
    logic                              last_elem;

    assign a_addr    = IDX_W'(int'(row) * N + int'(k));
    assign b_addr    = IDX_W'(int'(k) * N + int'(col));
    assign mac_prod  = $signed(a_mem[a_addr]) * $signed(b_mem[b_addr]);
    assign acc_ext   = (OUT_BYTES*8)'(acc);
    assign last_elem = (row == LAST_DIM) && (col == LAST_DIM);

    always_comb begin
        byte_sel = '0;
        for (int b = 0; b < OUT_BYTES; b++) begin
            if (byte_idx == BYTE_W'(b)) byte_sel = acc_ext[8*(OUT_BYTES-1-b) +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == CMD_LOAD)        state_next = LOAD_A;
                    else if (in_data == CMD_REPLAY) state_next = COMPUTE;
                    else                            state_next = ERR;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && load_idx == LAST_IDX) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && load_idx == LAST_IDX) state_next = COMPUTE;
            end
            COMPUTE: begin
                if (k == LAST_DIM) state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = byte_sel;
                if (out_ready && byte_idx == LAST_BYTE)
                    state_next = last_elem ? IDLE : COMPUTE;
            end
            ERR: begin
                out_valid = 1'b1;
                out_data  = ERR_BYTE;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Indices and accumulator are parked at zero in IDLE, so every entry into COMPUTE starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
            load_idx <= '0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            acc      <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    load_idx <= '0;
                    row      <= '0;
                    col      <= '0;
                    k        <= '0;
                    acc      <= '0;
                    byte_idx <= '0;
                end
                LOAD_A: begin
                    if (in_valid) begin
                        a_mem[load_idx] <= in_data;
                        load_idx        <= (load_idx == LAST_IDX) ? '0 : load_idx + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        b_mem[load_idx] <= in_data;
                        load_idx        <= (load_idx == LAST_IDX) ? '0 : load_idx + 1'b1;
                    end
                end
                COMPUTE: begin
                    acc      <= acc + ACC_W'(mac_prod);
                    k        <= (k == LAST_DIM) ? '0 : k + 1'b1;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (out_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= '0;
                            acc      <= '0;
                            if (col == LAST_DIM) begin
                                col <= '0;
                                row <= (row == LAST_DIM) ? '0 : row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_matmul_core.sv
// Directed bench for uart_matmul_core (N=2): expected byte queue from literals and a plain
// arithmetic matrix model, checked by one monitor on every output transfer.
module tb_uart_matmul_core;
    localparam int N         = 2;
    localparam int OUT_BYTES = 3;
    localparam int NB        = N * N * OUT_BYTES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    uart_matmul_core #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rx   = 0;
    int or_mode = 0;           // 0: always ready, 1: held low, 2: random
    logic [7:0] exp_q [$];

    logic [7:0] a030 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] b030 [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] lit030 [NB] = '{8'h00,8'h00,8'h13, 8'h00,8'h00,8'h16, 8'h00,8'h00,8'h2B, 8'h00,8'h00,8'h32};
    logic [7:0] a031 [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
    logic [7:0] b031 [4] = '{8'h02, 8'h00, 8'h00, 8'h02};
    logic [7:0] lit031 [NB] = '{8'hFF,8'hFF,8'hFE, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h02};
    logic [7:0] m80 [4] = '{8'h80, 8'h80, 8'h80, 8'h80};
    logic [7:0] lit032 [NB] = '{8'h00,8'h80,8'h00, 8'h00,8'h80,8'h00, 8'h00,8'h80,8'h00, 8'h00,8'h80,8'h00};
    logic [7:0] amix [4] = '{8'h7F, 8'h80, 8'hFE, 8'h03};
    logic [7:0] bmix [4] = '{8'h80, 8'h7F, 8'h05, 8'hFB};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], sign-extended, MSB first.
    task automatic push_model(input logic [7:0] a [4], input logic [7:0] b [4]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int c = 0;
                for (int kk = 0; kk < N; kk++)
                    c += int'($signed(a[i*N+kk])) * int'($signed(b[kk*N+j]));
                for (int bb = OUT_BYTES - 1; bb >= 0; bb--)
                    exp_q.push_back(8'((c >>> (8*bb)) & 255));
            end
    endtask

    task automatic push_lit(input logic [7:0] v [NB]);
        for (int i = 0; i < NB; i++) exp_q.push_back(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_mat(input logic [7:0] a [4], input logic [7:0] b [4]);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(a[i]);
        for (int i = 0; i < 4; i++) send_byte(b[i]);
    endtask

    task automatic drain(input string name, input int exp_bytes, input int rx0);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_count"}, 32'(n_rx - rx0), 32'(exp_bytes));
    endtask

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic       stall = 1'b0;
    logic [7:0] held  = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) chk("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
            if (!busy) chk("idle_no_valid", 32'(out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
                else                   chk("out_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                n_rx++;
                stall = 1'b0;
            end else if (out_valid) begin
                stall = 1'b1;
                held  = out_data;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        int rx0;
        int t;
        logic [7:0] zero [NB];

        // model pinned against hand-computed product
        push_model(a030, b030);
        for (int i = 0; i < NB; i++) chk("model_pin", {24'd0, exp_q[i]}, {24'd0, lit030[i]});
        exp_q.delete();
        for (int i = 0; i < NB; i++) zero[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #3; rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        rx0 = n_rx; push_lit(lit030); send_mat(a030, b030); drain("t030", NB, rx0);
        rx0 = n_rx; push_lit(lit031); send_mat(a031, b031); drain("t031", NB, rx0);
        rx0 = n_rx; push_lit(lit032); send_mat(m80, m80);   drain("t032", NB, rx0);
        rx0 = n_rx; push_lit(lit032); send_byte(8'h5A);     drain("t032_replay", NB, rx0);

        // bad command with stalled consumer
        or_mode = 1;
        rx0 = n_rx; exp_q.push_back(8'hEE); send_byte(8'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_valid", 32'(out_valid), 32'd1);
            chk("err_data", {24'd0, out_data}, 32'hEE);
            chk("err_in_ready", 32'(in_ready), 32'd0);
        end
        or_mode = 0;
        drain("t033", 1, rx0);
        @(negedge clk);
        chk("err_back_idle", 32'(in_ready), 32'd1);

        // random backpressure
        or_mode = 2;
        rx0 = n_rx; push_model(a030, b030); send_mat(a030, b030); drain("t035", NB, rx0);
        rx0 = n_rx; push_model(amix, bmix); send_mat(amix, bmix); drain("tmix", NB, rx0);
        rx0 = n_rx; push_model(amix, bmix); send_byte(8'h5A);     drain("tmix_replay", NB, rx0);
        or_mode = 0;

        // reset during LOAD_B clears storage
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(a030[i]);
        for (int i = 0; i < 3; i++) send_byte(b030[i]);
        @(posedge clk); #3; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #3; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        rx0 = n_rx; push_lit(zero); send_byte(8'h5A); drain("t034", NB, rx0);

        // reset while SEND is stalled: no bytes may follow
        rx0 = n_rx;
        send_mat(a030, b030);
        or_mode = 1;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reach_send", 32'(out_valid), 32'd1);
        @(posedge clk); #3; rst = 1'b1;
        @(negedge clk);
        chk("abort_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #3; rst = 1'b0; or_mode = 0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("abort_no_bytes", 32'(n_rx - rx0), 32'd0);
        rx0 = n_rx; exp_q.push_back(8'hEE); send_byte(8'h00); drain("t_after_abort", 1, rx0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_matmul_core.md
UART_MATMUL_CORE -- requirements
Module: uart_matmul_core

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning matrix dimension (legal 2..4).
REQ-002 The block SHALL derive localparam ACC_W = 16 + clog2(N), the signed accumulator width.
REQ-003 The block SHALL derive localparam OUT_BYTES = (ACC_W+7)/8, the bytes sent per result element.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_data  input  8  command or operand byte.
REQ-007 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-008 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 The block SHALL have port out_data  output  8  result byte.
REQ-010 The block SHALL have port out_valid  output  1  out_data is valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 An input byte SHALL transfer only on a cycle with in_valid && in_ready; an output byte SHALL transfer only on out_valid && out_ready.
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, COMPUTE, SEND, ERR.
REQ-015 in_ready SHALL be 1 in IDLE, LOAD_A and LOAD_B and 0 in COMPUTE, SEND and ERR.
REQ-016 In IDLE, an accepted byte 0xA5 SHALL go to LOAD_A; 0x5A SHALL go to COMPUTE using the stored A and B (replay); any other byte SHALL go to ERR.
REQ-017 LOAD_A SHALL accept exactly N*N bytes as signed 8-bit A elements, row-major, then go to LOAD_B; LOAD_B SHALL do the same for B, then go to COMPUTE.
REQ-018 Gaps (in_valid low) during LOAD_A/LOAD_B SHALL be tolerated indefinitely, with no timeout.
REQ-019 Result elements C[i][j] = sum over k of A[i][k]*B[k][j] SHALL be produced in row-major order, each element as one COMPUTE pass followed by one SEND pass.
REQ-020 COMPUTE SHALL take exactly N cycles per element, one signed 8x8 MAC per cycle into the ACC_W-bit accumulator, cleared at the start of each element; the accumulator SHALL never overflow.
REQ-021 SEND SHALL present OUT_BYTES bytes of the sign-extended accumulator, most-significant byte first.
REQ-022 out_data SHALL be held stable and out_valid held high until the byte is accepted; out_valid SHALL be 0 outside SEND and ERR.
REQ-023 After the last byte of an element, SEND SHALL go to COMPUTE for the next element; after the last byte of C[N-1][N-1] it SHALL go to IDLE.
REQ-024 ERR SHALL present the single byte 0xEE, then return to IDLE on acceptance.
REQ-025 Stored A and B SHALL remain unchanged after a multiply, so that 0x5A replays the identical result.
REQ-026 An aborted load SHALL leave partially overwritten storage, with no rollback.
REQ-027 Total output per multiply SHALL be exactly N*N*OUT_BYTES bytes.

Reset
REQ-028 While rst is high, state SHALL be IDLE; out_valid, busy and out_data SHALL be 0; in_ready SHALL be 1 after release; all A/B storage, indices and the accumulator SHALL be 0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort immediately with no further output bytes, and the block SHALL accept a command on the first cycle after release.

Verification
REQ-030 N=2, send A5 01 02 03 04 05 06 07 08 with out_ready=1 -> bytes 00 00 13 00 00 16 00 00 2B 00 00 32, then busy=0.
REQ-031 N=2, send A5 FF 00 00 01 02 00 00 02 -> bytes FF FF FE 00 00 00 00 00 00 00 00 02.
REQ-032 N=2, send A5 80 80 80 80 80 80 80 80 -> every element 00 80 00 (32768); then send 5A -> the identical 12 bytes.
REQ-033 Send 33 in IDLE -> single byte EE, in_ready=0 until accepted, then IDLE; out_ready held low 5 cycles -> out_data=EE stable throughout.
REQ-034 Assert rst after the 3rd byte of LOAD_B, release, send 5A -> 12 bytes of 00 (storage cleared) and busy=0 at end.
REQ-035 Toggle out_ready randomly during REQ-030 -> the same byte sequence, with no byte dropped or duplicated.
